// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: sequential fetch over a single-outstanding imem handshake,
// a DEPTH-entry {pc,npc,instr,adel} queue toward IF/ID. Optional macro IFQ_BYPASS_EN.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_npc,
  output logic        out_adel
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;

  logic [31:0] r_pc_q    [DEPTH];
  logic [31:0] r_npc_q   [DEPTH];
  logic [31:0] r_instr_q [DEPTH];
  logic        r_adel_q  [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic w_ack, w_push, w_fifo_push, w_pop;
  logic w_head_valid, w_misaligned, w_outstanding;

  assign w_ack         = imem_ack & r_req;
  assign w_push        = w_ack & (r_state == WAIT) & ~redirect;
  assign w_head_valid  = (r_count != '0);
  assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
  assign w_outstanding = r_req & ~imem_ack;
  assign w_pop         = w_head_valid & out_ready & ~redirect;

  assign imem_req  = r_req;
  assign imem_addr = r_addr;

`ifdef IFQ_BYPASS_EN
  // An empty queue lets the acked word reach IF/ID in the ack cycle.
  logic w_bypass_avail;
  assign w_bypass_avail = w_push & ~w_head_valid;
  assign out_valid   = w_head_valid | w_bypass_avail;
  assign out_pc      = w_bypass_avail ? r_fetch_pc          : r_pc_q[r_rptr];
  assign out_npc     = w_bypass_avail ? r_fetch_pc + 32'd4  : r_npc_q[r_rptr];
  assign out_instr   = w_bypass_avail ? imem_rdata          : r_instr_q[r_rptr];
  assign out_adel    = w_bypass_avail ? 1'b0                : r_adel_q[r_rptr];
  assign w_fifo_push = w_push & ~(w_bypass_avail & out_ready);
`else
  assign out_valid   = w_head_valid;
  assign out_pc      = r_pc_q[r_rptr];
  assign out_npc     = r_npc_q[r_rptr];
  assign out_instr   = r_instr_q[r_rptr];
  assign out_adel    = r_adel_q[r_rptr];
  assign w_fifo_push = w_push;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  // A cancelled request keeps req/addr stable; only fetch_pc moves to the target.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect) begin
      w_fetch_pc_nxt = redirect_pc;
      if (w_outstanding) begin
        w_state_nxt = DRAIN;
      end else if (w_misaligned) begin
        w_state_nxt = HALT;
        w_req_nxt   = 1'b0;
      end else begin
        w_state_nxt = WAIT;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = redirect_pc;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (r_count < CW'(DEPTH)) begin
            w_state_nxt = WAIT;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_fetch_pc;
          end
        end
        WAIT: begin
          if (w_ack) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            if ((r_count + CW'(w_fifo_push)) < CW'(DEPTH)) begin
              w_addr_nxt = r_fetch_pc + 32'd4;
            end else begin
              w_state_nxt = IDLE;
              w_req_nxt   = 1'b0;
            end
          end
        end
        DRAIN: begin
          if (w_ack) begin
            if (r_fetch_pc[1:0] != 2'b00) begin
              w_state_nxt = HALT;
              w_req_nxt   = 1'b0;
            end else begin
              w_state_nxt = WAIT;
              w_addr_nxt  = r_fetch_pc;
            end
          end
        end
        HALT: begin
          w_req_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
        end
      endcase
    end
  end

  // A misaligned redirect replaces the queue with a single address-error entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i]    <= '0;
        r_npc_q[i]   <= '0;
        r_instr_q[i] <= '0;
        r_adel_q[i]  <= 1'b0;
      end
    end else if (redirect) begin
      r_rptr <= '0;
      if (w_misaligned) begin
        r_pc_q[0]    <= redirect_pc;
        r_npc_q[0]   <= redirect_pc + 32'd4;
        r_instr_q[0] <= '0;
        r_adel_q[0]  <= 1'b1;
        r_wptr       <= PW'(1);
        r_count      <= CW'(1);
      end else begin
        r_wptr  <= '0;
        r_count <= '0;
      end
    end else begin
      if (w_fifo_push) begin
        r_pc_q[r_wptr]    <= r_fetch_pc;
        r_npc_q[r_wptr]   <= r_fetch_pc + 32'd4;
        r_instr_q[r_wptr] <= imem_rdata;
        r_adel_q[r_wptr]  <= 1'b0;
        r_wptr            <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= r_count + CW'(w_fifo_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue: transaction-level queue model of the fetch stream,
// plus directed sequences for stall, redirect, address-error and mid-fetch reset.
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_npc;
  logic        out_adel;

  int checks = 0;
  int errors = 0;
  int popCount = 0;

  entry_t      modelQ[$];
  logic [31:0] expFetch;
  logic        drainPending;
  logic [31:0] drainAddr;
  logic        halted;
  logic        expectIssue;
  logic [31:0] expectIssueAddr;
  logic        prevHeld;
  logic [31:0] prevAddr;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_npc(out_npc), .out_adel(out_adel)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearModel();
    modelQ.delete();
    expFetch     = RESET_PC;
    drainPending = 1'b0;
    halted       = 1'b0;
    prevHeld     = 1'b0;
    expectIssue  = 1'b1;
    expectIssueAddr = RESET_PC;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstReq",   32'(imem_req),  32'd0);
    checkOutput("rstAddr",  imem_addr,      32'd0);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstAdel",  32'(out_adel),  32'd0);
    checkOutput("rstPc",    out_pc,         32'd0);
    checkOutput("rstNpc",   out_npc,        32'd0);
    checkOutput("rstInstr", out_instr,      32'd0);
  endtask

  // Observations after an edge, before the next stimulus is applied.
  task automatic checkState();
    logic [31:0] addrLow;
    checkOutput("outValid", 32'(out_valid), 32'(modelQ.size() != 0));
    checkOutput("credit", 32'((modelQ.size() + int'(imem_req)) <= DEPTH), 32'd1);
    if (imem_req) begin
      addrLow = {30'd0, imem_addr[1:0]};
      checkOutput("addrAligned", addrLow, 32'd0);
    end
    if (prevHeld) begin
      checkOutput("reqHeld", 32'(imem_req), 32'd1);
      checkOutput("addrStable", imem_addr, prevAddr);
    end
    if (halted && !drainPending) checkOutput("haltNoReq", 32'(imem_req), 32'd0);
    if (expectIssue) begin
      checkOutput("issueReq", 32'(imem_req), 32'd1);
      checkOutput("issueAddr", imem_addr, expectIssueAddr);
      expectIssue = 1'b0;
    end
  endtask

  task automatic updateModel(input logic sRedirect, input logic [31:0] rpc);
    entry_t e;
    logic sReq, sAck, sValid, sReady;
    logic [31:0] sAddr;
    sReq = imem_req; sAck = imem_ack; sValid = out_valid; sReady = out_ready; sAddr = imem_addr;
    if (sRedirect) begin
      if (sReq && !sAck) begin
        drainPending = 1'b1;
        drainAddr    = sAddr;
      end else begin
        drainPending = 1'b0;
      end
      modelQ.delete();
      expFetch = rpc;
      halted   = (rpc % 4) != 0;
      if (halted) begin
        e.pc = rpc; e.npc = rpc + 32'd4; e.instr = 32'd0; e.adel = 1'b1;
        modelQ.push_back(e);
      end else if (!drainPending) begin
        expectIssue     = 1'b1;
        expectIssueAddr = rpc;
      end
    end else begin
      if (sValid && sReady) begin
        if (modelQ.size() == 0) begin
          checkOutput("popEmpty", 32'd1, 32'd0);
        end else begin
          e = modelQ.pop_front();
          checkOutput("outPc", out_pc, e.pc);
          checkOutput("outNpc", out_npc, e.npc);
          checkOutput("outInstr", out_instr, e.instr);
          checkOutput("outAdel", 32'(out_adel), 32'(e.adel));
          popCount++;
        end
      end
      if (sReq && sAck) begin
        if (drainPending) begin
          checkOutput("drainAddr", sAddr, drainAddr);
          drainPending = 1'b0;
          if (!halted) begin
            expectIssue     = 1'b1;
            expectIssueAddr = expFetch;
          end
        end else begin
          checkOutput("fetchAddr", sAddr, expFetch);
          e.pc = expFetch; e.npc = expFetch + 32'd4; e.instr = imem_rdata; e.adel = 1'b0;
          modelQ.push_back(e);
          expFetch = expFetch + 32'd4;
        end
      end
    end
    prevHeld = sReq && !sAck;
    prevAddr = sAddr;
  endtask

  task automatic applyStimulus(input logic doRedirect, input logic [31:0] rpc,
                               input int readyPct, input int ackPct);
    @(negedge clk);
    checkState();
    redirect    = doRedirect;
    redirect_pc = rpc;
    out_ready   = int'($urandom_range(99)) < readyPct;
    if (imem_req) imem_ack = int'($urandom_range(99)) < ackPct;
    else          imem_ack = (ackPct > 0) && (int'($urandom_range(99)) < 3);
    imem_rdata  = $urandom;
    #1;
    updateModel(doRedirect, rpc);
  endtask

  task automatic runCycles(input int n, input int readyPct, input int ackPct);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, readyPct, ackPct);
  endtask

  task automatic waitForReq(input int budget);
    int waited = 0;
    while (!imem_req && waited < budget) begin
      applyStimulus(1'b0, 32'd0, 0, 0);
      waited++;
    end
    checkOutput("waitReq", 32'(imem_req), 32'd1);
  endtask

  function automatic logic [31:0] randPc();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(9))
      0:       return 32'hfffffff8;
      1:       return {r[31:2], 2'b10};
      default: return {r[31:2], 2'b00};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    clearModel();
    repeat (3) @(negedge clk);
    checkResetOutputs();
    rst_n = 1'b1;

    // Streaming fetch from the reset vector.
    runCycles(12, 100, 100);

    // Stall: queue fills to DEPTH and requests stop, then drains in order.
    runCycles(20, 0, 100);
    checkOutput("bufferedCount", 32'(modelQ.size()), 32'(DEPTH));
    checkOutput("fullNoReq", 32'(imem_req), 32'd0);
    runCycles(12, 100, 100);

    // Redirect while a request is outstanding; the stale word is dropped.
    waitForReq(10);
    applyStimulus(1'b1, 32'h80000100, 100, 0);
    runCycles(3, 100, 0);
    runCycles(8, 100, 100);

    // Redirect coinciding with an ack and a pop.
    runCycles(6, 100, 0);
    runCycles(2, 0, 100);
    waitForReq(10);
    checkOutput("queuedBeforeRedirect", 32'(modelQ.size() != 0), 32'd1);
    applyStimulus(1'b1, 32'h80002000, 100, 100);
    runCycles(8, 100, 100);

    // Misaligned target: one address-error entry, then silence until redirected.
    applyStimulus(1'b1, 32'h00400002, 0, 100);
    runCycles(8, 0, 100);
    runCycles(3, 100, 100);
    applyStimulus(1'b1, 32'hbfc00380, 100, 100);
    runCycles(8, 100, 100);

    // Reset in the middle of a fetch with three entries queued.
    runCycles(6, 100, 0);
    runCycles(3, 0, 100);
    checkOutput("queuedBeforeReset", 32'(modelQ.size()), 32'd3);
    runCycles(1, 0, 0);
    #1;
    rst_n = 1'b0;
    imem_ack = 1'b1;
    #1;
    checkResetOutputs();
    repeat (2) @(negedge clk);
    clearModel();
    rst_n = 1'b1;
    runCycles(10, 100, 100);

    // Randomized traffic with occasional redirects, including wrap and misaligned targets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) applyStimulus(1'b1, randPc(), 70, 50);
      else                        applyStimulus(1'b0, 32'd0, 70, 50);
    end
    checkOutput("progress", 32'(popCount > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
